// File: rtl/uart_debug_core_pkg.sv
// Shared parity selectors and RX/TX state encodings for the UART debug core.
package uart_debug_core_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees the slot a same-cycle push needs when full.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_debug_core.sv
// UART debug core: synchronised RX with parity/frame/overrun checks into a FIFO, TX engine,
// optional echo of received bytes and active-low LED view of the last good byte.
module uart_debug_core
  import uart_debug_core_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LED_W      = 6,
  parameter int unsigned ECHO       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [LED_W-1:0]     led
);

  localparam int unsigned DIV     = CLK_FREQ / BAUD;
  localparam int unsigned HALF    = DIV / 2;
  localparam int unsigned CW      = $clog2(DIV);
  localparam int unsigned BW      = $clog2(DATA_BITS);
  localparam bit          HAS_PAR = (PARITY != PARITY_NONE);
  localparam bit          ECHO_EN = (ECHO != 0);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  rx_state_e            rx_state_q, rx_state_d;
  tx_state_e            tx_state_q, tx_state_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic                 rx_par_q, rx_par_d, tx_par_q, tx_par_d;
  logic                 rx_good_q, rx_good_d;
  logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic                 tx_pin_q, tx_pin_d, tx_ready_q, tx_ready_d;
  logic                 fifo_full, fifo_empty, pop_c, accept_c, tx_start_c, par_bad_c;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_good_q),
    .pop   (pop_c),
    .wdata (rx_sh_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // In echo mode the transmitter drains the FIFO itself and the user-side handshakes go dead.
  assign pop_c      = ECHO_EN ? (tx_state_q == TX_IDLE) && !fifo_empty : rx_ready && !fifo_empty;
  assign tx_start_c = ECHO_EN ? (tx_state_q == TX_IDLE) && !fifo_empty : tx_valid && tx_ready_q;
  assign accept_c   = rx_good_q && (!fifo_full || pop_c);
  assign par_bad_c  = HAS_PAR && (rx_par_q != par_bit(rx_sh_q));

  assign rx_data    = fifo_rdata;
  assign rx_valid   = !ECHO_EN && !fifo_empty;
  assign tx_pin     = tx_pin_q;
  assign tx_ready   = tx_ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign led        = led_q;

  // RX next state: start-bit qualification at half bit, then centre sampling every DIV clocks.
  always_comb begin
    rx_s1_d      = rx_pin;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CW'(1);
    rx_idx_d     = rx_idx_q;
    rx_sh_d      = rx_sh_q;
    rx_par_d     = rx_par_q;
    rx_good_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = rx_good_q && !accept_c;
    led_d        = accept_c ? ~rx_sh_q[LED_W-1:0] : led_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        rx_idx_d = rx_idx_q + BW'(1);
        if (rx_idx_q == BW'(DATA_BITS - 1)) rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_s2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_state_d   = RX_IDLE;
        frame_err_d  = !rx_s2_q;
        parity_err_d = rx_s2_q && par_bad_c;
        rx_good_d    = rx_s2_q && !par_bad_c;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_sh_q      <= '0;
      rx_par_q     <= 1'b0;
      rx_good_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      led_q        <= '1;
    end else begin
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_sh_q      <= rx_sh_d;
      rx_par_q     <= rx_par_d;
      rx_good_q    <= rx_good_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      led_q        <= led_d;
    end
  end

  // TX next state; the pin is registered from the next state so it moves the cycle after a handshake.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_start_c) begin
          tx_sh_d    = ECHO_EN ? fifo_rdata : tx_data;
          tx_par_d   = par_bit(tx_sh_d);
          tx_idx_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == CW'(DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == CW'(DIV - 1)) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q + BW'(1);
        if (tx_idx_q == BW'(DATA_BITS - 1)) tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
      end
      TX_PAR: if (tx_cnt_q == CW'(DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == CW'(DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    unique case (tx_state_d)
      TX_START: tx_pin_d = 1'b0;
      TX_DATA:  tx_pin_d = tx_sh_d[0];
      TX_PAR:   tx_pin_d = tx_par_d;
      default:  tx_pin_d = 1'b1;
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE) && !ECHO_EN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pin_q   <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_pin_q   <= tx_pin_d;
      tx_ready_q <= tx_ready_d;
    end
  end

endmodule

// File: tb/tb_uart_debug_core.sv
// Directed bench: u0 is a plain 8N1 core with a 4-deep FIFO, u1 an even-parity echo core.
module tb_uart_debug_core;

  localparam int unsigned DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rx0, tx0, rx_valid0, rx_ready0, tx_valid0, tx_ready0, pe0, fe0, ov0;
  logic [7:0] rx_data0, tx_data0;
  logic [5:0] led0;
  logic       rst1, rx1, tx1, rx_valid1, rx_ready1, tx_valid1, tx_ready1, pe1, fe1, ov1;
  logic [7:0] rx_data1, tx_data1;
  logic [5:0] led1;

  int n_checks = 0;
  int n_fail   = 0;
  int pe0_n = 0, fe0_n = 0, ov0_n = 0, pe1_n = 0, fe1_n = 0, ov1_n = 0;

  uart_debug_core #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
    .FIFO_DEPTH(4), .LED_W(6), .ECHO(0)
  ) u0 (
    .clk(clk), .rst(rst0), .rx_pin(rx0), .tx_pin(tx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .led(led0)
  );

  uart_debug_core #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
    .FIFO_DEPTH(16), .LED_W(6), .ECHO(1)
  ) u1 (
    .clk(clk), .rst(rst1), .rx_pin(rx1), .tx_pin(tx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .led(led1)
  );

  // Pulse counters for the one-cycle error flags.
  always @(negedge clk) begin
    if (pe0) pe0_n <= pe0_n + 1;
    if (fe0) fe0_n <= fe0_n + 1;
    if (ov0) ov0_n <= ov0_n + 1;
    if (pe1) pe1_n <= pe1_n + 1;
    if (fe1) fe1_n <= fe1_n + 1;
    if (ov1) ov1_n <= ov1_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [7:0] d, input logic stop_lvl);
    logic [9:0] fr;
    fr = {stop_lvl, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx0 = fr[i];
      repeat (DIV) @(negedge clk);
    end
    rx0 = 1'b1;
  endtask

  task automatic send1(input logic [7:0] d, input logic par);
    logic [10:0] fr;
    fr = {1'b1, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx1 = fr[i];
      repeat (DIV) @(negedge clk);
    end
    rx1 = 1'b1;
  endtask

  initial begin
    logic [9:0]  cap10;
    logic [10:0] cap11;
    int          w;
    int          lows;

    rst0 = 1'b1; rst1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    rx_ready0 = 1'b0; rx_ready1 = 1'b0; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
    tx_data0 = 8'h00; tx_data1 = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_tx_pin0",   tx0, 1);
    check("rst_rx_valid0", rx_valid0, 0);
    check("rst_tx_ready0", tx_ready0, 0);
    check("rst_led0",      led0, 6'h3f);
    check("rst_flags0",    {pe0, fe0, ov0}, 0);
    check("rst_tx_pin1",   tx1, 1);
    check("rst_led1",      led1, 6'h3f);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("tx_ready0_after_rst", tx_ready0, 1);
    check("tx_ready1_echo",      tx_ready1, 0);

    // Single good byte.
    send0(8'hA5, 1'b1);
    check("a5_valid", rx_valid0, 1);
    check("a5_data",  rx_data0, 8'hA5);
    check("a5_led",   led0, 6'b011010);
    check("a5_no_err", pe0_n + fe0_n + ov0_n, 0);
    rx_ready0 = 1'b1; @(negedge clk); rx_ready0 = 1'b0;
    check("a5_popped", rx_valid0, 0);

    // Stop bit held low.
    send0(8'h5A, 1'b0);
    repeat (5) @(negedge clk);
    check("ferr_count",   fe0_n, 1);
    check("ferr_no_perr", pe0_n, 0);
    check("ferr_no_push", rx_valid0, 0);
    check("ferr_led",     led0, 6'b011010);

    // Three-cycle glitch on idle line, then a normal byte.
    rx0 = 1'b0; repeat (3) @(negedge clk); rx0 = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_push", rx_valid0, 0);
    check("glitch_no_flag", pe0_n + fe0_n + ov0_n, 1);
    send0(8'h11, 1'b1);
    check("post_glitch_data", rx_data0, 8'h11);
    check("post_glitch_led",  led0, 6'b101110);
    rx_ready0 = 1'b1; @(negedge clk); rx_ready0 = 1'b0;

    // Overrun: five bytes into a four-entry FIFO.
    for (int b = 1; b <= 5; b++) send0(8'(b), 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_count", ov0_n, 1);
    check("ovr_valid", rx_valid0, 1);
    check("ovr_led",   led0, 6'b111011);
    for (int b = 1; b <= 4; b++) begin
      check("ovr_pop_order", rx_data0, 32'(b));
      rx_ready0 = 1'b1; @(negedge clk); rx_ready0 = 1'b0;
    end
    check("ovr_drained", rx_valid0, 0);

    // Transmit 0x3C and check every bit centre plus frame length.
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    check("tx_ready_idle", tx_ready0, 1);
    @(negedge clk);
    tx_valid0 = 1'b0;
    check("tx_ready_busy", tx_ready0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      cap10[i] = tx0;
      if (i < 9) repeat (DIV) @(negedge clk);
    end
    check("tx_frame_3c", cap10, {1'b1, 8'h3C, 1'b0});
    repeat (5) @(negedge clk);
    check("tx_ready_c100", tx_ready0, 0);
    @(negedge clk);
    check("tx_ready_c101", tx_ready0, 1);
    check("tx_pin_idle",   tx0, 1);

    // Even parity mismatch on u1: 0x01 needs parity 1, send 0.
    send1(8'h01, 1'b0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx1 == 1'b0) lows++;
      @(negedge clk);
    end
    check("perr_count",   pe1_n, 1);
    check("perr_no_ferr", fe1_n, 0);
    check("perr_led",     led1, 6'h3f);
    check("perr_no_echo", lows, 0);

    // Echo of 0x55 with even parity bit 0.
    send1(8'h55, 1'b0);
    w = 0;
    while (tx1 !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("echo_started", (w < 40), 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cap11[i] = tx1;
      if (i < 10) repeat (DIV) @(negedge clk);
    end
    check("echo_frame_55", cap11, {1'b1, 1'b0, 8'h55, 1'b0});
    check("echo_led",      led1, 6'b101010);
    check("echo_rx_valid", rx_valid1, 0);

    // Reset in the middle of an echo frame.
    send1(8'h33, 1'b0);
    w = 0;
    while (tx1 !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("echo2_started", (w < 40), 1);
    repeat (30) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_pin", tx1, 1);
    @(negedge clk);
    rst1 = 1'b0;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      if (tx1 == 1'b0) lows++;
      @(negedge clk);
    end
    check("rst_mid_no_reecho", lows, 0);
    check("rst_mid_led",       led1, 6'h3f);
    check("u1_no_ovr_ferr",    ov1_n + fe1_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
